// File: rtl/count_seg_display.sv
// count_seg_display
// Display stage for the 5-bit free-running event counter. Captures the
// counter value, converts it to two BCD digits with a compare/subtract
// chain, and scans them onto a 2-digit multiplexed 7-segment display.
// A one-cycle wrap_pulse flags each sampled 31 -> 0 transition.
//
// Pipeline: count -> cap (1 cycle) -> bcd_* (2 cycles) -> seg/an (3 cycles).
// an and seg are registered together, so they always change on the same
// edge and never disagree for part of a cycle.

module count_seg_display #(
    parameter int SCAN_DIV = 4,     // clk cycles per digit, >= 2
    parameter bit BLANK_LZ = 1'b1   // 1 = blank tens digit when it is 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] count,
    input  logic       hold,
    output logic [6:0] seg,
    output logic [1:0] an,
    output logic [3:0] bcd_tens,
    output logic [3:0] bcd_ones,
    output logic       wrap_pulse
);

    localparam int SCAN_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);

    localparam logic [6:0] SEG_BLANK = 7'h00;
    localparam logic [6:0] SEG_ZERO  = 7'h3F;

    // Segment pattern for one decimal digit, {g,f,e,d,c,b,a}, active-high.
    // Codes above 9 cannot reach here; they show a blank digit.
    function automatic logic [6:0] encode(input logic [3:0] digit);
        logic [6:0] pattern;
        case (digit)
            4'd0:    pattern = 7'h3F;
            4'd1:    pattern = 7'h06;
            4'd2:    pattern = 7'h5B;
            4'd3:    pattern = 7'h4F;
            4'd4:    pattern = 7'h66;
            4'd5:    pattern = 7'h6D;
            4'd6:    pattern = 7'h7D;
            4'd7:    pattern = 7'h07;
            4'd8:    pattern = 7'h7F;
            4'd9:    pattern = 7'h6F;
            default: pattern = SEG_BLANK;
        endcase
        return pattern;
    endfunction

    logic [4:0]        cap;
    logic [SCAN_W-1:0] scan_cnt;
    logic              dig_sel;

    logic [3:0]        tens_next;
    logic [3:0]        ones_next;
    logic [3:0]        shown_digit;
    logic [6:0]        seg_next;
    logic [1:0]        an_next;

    // Stage 1: sample the counter unless frozen, and flag a 31 -> 0 step.
    // hold wins over a coincident wrap: cap keeps 31 and no pulse is raised.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: registers take non-blocking (<=) so every flop in this block
        // samples its inputs from before the edge, independent of statement order.
        if (reset) begin
            cap        <= 5'd0;
            wrap_pulse <= 1'b0;
        end else begin
            if (!hold) begin
                cap <= count;
            end
            wrap_pulse <= !hold && (cap == 5'd31) && (count == 5'd0);
        end
    end

    // Binary -> BCD for 0..31 by comparing against 30/20/10 and subtracting.
    always_comb begin
        // NOTE: both outputs get a default before any branch so no path
        // leaves them unassigned, which would otherwise infer a latch.
        tens_next = 4'd0;
        ones_next = 4'(cap);
        if (cap >= 5'd30) begin
            tens_next = 4'd3;
            ones_next = 4'(cap - 5'd30);
        end else if (cap >= 5'd20) begin
            tens_next = 4'd2;
            ones_next = 4'(cap - 5'd20);
        end else if (cap >= 5'd10) begin
            tens_next = 4'd1;
            ones_next = 4'(cap - 5'd10);
        end
    end

    // Stage 2: register the BCD digits.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bcd_tens <= 4'd0;
            bcd_ones <= 4'd0;
        end else begin
            bcd_tens <= tens_next;
            bcd_ones <= ones_next;
        end
    end

    // Scan timer: each digit stays selected for SCAN_DIV cycles, ignoring hold.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            scan_cnt <= '0;
            dig_sel  <= 1'b0;
        end else if (scan_cnt == SCAN_LAST) begin
            scan_cnt <= '0;
            dig_sel  <= ~dig_sel;
        end else begin
            scan_cnt <= scan_cnt + 1'b1;
        end
    end

    // Pick the selected digit and its segment pattern, blanking a leading zero.
    always_comb begin
        shown_digit = dig_sel ? bcd_tens : bcd_ones;
        an_next     = dig_sel ? 2'b10 : 2'b01;
        seg_next    = encode(shown_digit);
        if (BLANK_LZ && dig_sel && (bcd_tens == 4'd0)) begin
            seg_next = SEG_BLANK;
        end
    end

    // Stage 3: register digit enable and segments on the same edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            an  <= 2'b01;
            seg <= SEG_ZERO;
        end else begin
            an  <= an_next;
            seg <= seg_next;
        end
    end

endmodule

// File: tb/tb_count_seg_display.sv
// tb_count_seg_display
// Directed bench for count_seg_display. Two instances share the inputs:
// dut uses the default BLANK_LZ=1, dut_nb uses BLANK_LZ=0. Inputs change
// 1 time unit after a rising edge and outputs are sampled at that point.

module tb_count_seg_display;

    logic       clk;
    logic       reset;
    logic [4:0] count;
    logic       hold;

    logic [6:0] seg;
    logic [1:0] an;
    logic [3:0] bcd_tens;
    logic [3:0] bcd_ones;
    logic       wrap_pulse;

    logic [6:0] seg_nb;
    logic [1:0] an_nb;
    logic [3:0] bcd_tens_nb;
    logic [3:0] bcd_ones_nb;
    logic       wrap_pulse_nb;

    int n_assert = 0;
    int n_fail   = 0;

    count_seg_display #(.SCAN_DIV(4), .BLANK_LZ(1'b1)) dut (
        .clk        (clk),
        .reset      (reset),
        .count      (count),
        .hold       (hold),
        .seg        (seg),
        .an         (an),
        .bcd_tens   (bcd_tens),
        .bcd_ones   (bcd_ones),
        .wrap_pulse (wrap_pulse)
    );

    count_seg_display #(.SCAN_DIV(4), .BLANK_LZ(1'b0)) dut_nb (
        .clk        (clk),
        .reset      (reset),
        .count      (count),
        .hold       (hold),
        .seg        (seg_nb),
        .an         (an_nb),
        .bcd_tens   (bcd_tens_nb),
        .bcd_ones   (bcd_ones_nb),
        .wrap_pulse (wrap_pulse_nb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed,
                         input logic [31:0] expected);
        n_assert++;
        assert (observed === expected)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Advance n rising edges, stopping 1 unit after the last one.
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Pulse reset between edges; the next rising edge is edge 1 after release.
    task automatic do_reset();
        @(posedge clk);
        #1;
        reset = 1'b1;
        #2;
        reset = 1'b0;
    endtask

    // Watchdog: the directed sequence is short; this only guards a hang.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [1:0] exp_an;
        logic [6:0] exp_seg;

        reset = 1'b0;
        count = 5'd0;
        hold  = 1'b0;

        // ---- Reset values, asynchronous ----
        #2 reset = 1'b1;
        #1;
        check("rst_an",       32'(an),         32'h1);
        check("rst_seg",      32'(seg),        32'h3F);
        check("rst_tens",     32'(bcd_tens),   32'h0);
        check("rst_ones",     32'(bcd_ones),   32'h0);
        check("rst_wrap",     32'(wrap_pulse), 32'h0);
        check("rst_cap",      32'(dut.cap),    32'h0);
        check("rst_scan_cnt", 32'(dut.scan_cnt), 32'h0);

        // Release; first dig_sel toggle on edge 4, an follows on edge 5.
        @(posedge clk);
        #1;
        reset = 1'b0;
        tick(3);
        check("dig_sel_e3", 32'(dut.dig_sel), 32'h0);
        check("an_e3",      32'(an),          32'h1);
        tick(1);
        check("dig_sel_e4", 32'(dut.dig_sel), 32'h1);
        check("an_e4",      32'(an),          32'h1);
        tick(1);
        check("an_e5",      32'(an),          32'h2);
        check("seg_e5_blank", 32'(seg),       32'h00);
        check("seg_nb_e5",  32'(seg_nb),      32'h3F);

        // ---- count = 17: BCD after 2 edges, then 4 ones / 4 tens slots ----
        count = 5'd17;
        do_reset();
        tick(1);
        check("c17_ones_e1", 32'(bcd_ones), 32'h0);
        check("c17_seg_e1",  32'(seg),      32'h3F);
        tick(1);
        check("c17_tens_e2", 32'(bcd_tens), 32'h1);
        check("c17_ones_e2", 32'(bcd_ones), 32'h7);
        for (int k = 3; k <= 12; k++) begin
            tick(1);
            exp_an  = (((k - 1) / 4) % 2 == 1) ? 2'b10 : 2'b01;
            exp_seg = (exp_an == 2'b10) ? 7'h06 : 7'h07;
            check($sformatf("c17_an_e%0d", k),  32'(an),  32'(exp_an));
            check($sformatf("c17_seg_e%0d", k), 32'(seg), 32'(exp_seg));
        end

        // ---- 30, 31, 0, 1: one wrap pulse aligned with cap == 0 ----
        count = 5'd30;
        tick(1);
        check("w30_wrap", 32'(wrap_pulse), 32'h0);
        count = 5'd31;
        tick(1);
        check("w31_wrap", 32'(wrap_pulse), 32'h0);
        check("w31_cap",  32'(dut.cap),    32'd31);
        count = 5'd0;
        tick(1);
        check("w0_wrap",  32'(wrap_pulse), 32'h1);
        check("w0_cap",   32'(dut.cap),    32'h0);
        count = 5'd1;
        tick(1);
        check("w1_wrap",  32'(wrap_pulse), 32'h0);
        check("w1_tens",  32'(bcd_tens),   32'h0);
        check("w1_ones",  32'(bcd_ones),   32'h0);

        // ---- 31 then 17 (counter reset): no pulse ----
        count = 5'd31;
        tick(1);
        check("r31_wrap", 32'(wrap_pulse), 32'h0);
        count = 5'd17;
        tick(1);
        check("r17_wrap", 32'(wrap_pulse), 32'h0);
        tick(1);
        check("r17_wrap2", 32'(wrap_pulse), 32'h0);
        check("r17_tens",  32'(bcd_tens),   32'h1);
        check("r17_ones",  32'(bcd_ones),   32'h7);

        // ---- count = 5: leading-zero blank vs. always-shown tens ----
        count = 5'd5;
        do_reset();
        tick(3);
        check("c5_an_e3",     32'(an),     32'h1);
        check("c5_seg_e3",    32'(seg),    32'h6D);
        check("c5_seg_nb_e3", 32'(seg_nb), 32'h6D);
        tick(2);
        check("c5_an_e5",     32'(an),     32'h2);
        check("c5_seg_e5",    32'(seg),    32'h00);
        check("c5_an_nb_e5",  32'(an_nb),  32'h2);
        check("c5_seg_nb_e5", 32'(seg_nb), 32'h3F);

        // ---- hold freezes BCD while count steps 21..25 ----
        count = 5'd20;
        do_reset();
        tick(2);
        check("h20_tens", 32'(bcd_tens), 32'h2);
        check("h20_ones", 32'(bcd_ones), 32'h0);
        hold = 1'b1;
        for (int c = 21; c <= 25; c++) begin
            count = 5'(c);
            tick(1);
            check($sformatf("h%0d_tens", c), 32'(bcd_tens),   32'h2);
            check($sformatf("h%0d_ones", c), 32'(bcd_ones),   32'h0);
            check($sformatf("h%0d_wrap", c), 32'(wrap_pulse), 32'h0);
        end

        // hold rising with a 31 -> 0 step: hold wins.
        hold  = 1'b0;
        count = 5'd31;
        tick(1);
        check("hw_cap31", 32'(dut.cap), 32'd31);
        hold  = 1'b1;
        count = 5'd0;
        tick(1);
        check("hw_cap_kept", 32'(dut.cap),    32'd31);
        check("hw_wrap",     32'(wrap_pulse), 32'h0);
        tick(1);
        check("hw_wrap2",    32'(wrap_pulse), 32'h0);
        check("hw_tens",     32'(bcd_tens),   32'h3);
        check("hw_ones",     32'(bcd_ones),   32'h1);
        hold = 1'b0;

        // ---- reset mid-scan at scan_cnt = 2, dig_sel = 1 ----
        count = 5'd17;
        do_reset();
        tick(6);
        check("mid_scan_cnt", 32'(dut.scan_cnt), 32'h2);
        check("mid_dig_sel",  32'(dut.dig_sel),  32'h1);
        check("mid_an",       32'(an),           32'h2);
        check("mid_seg",      32'(seg),          32'h06);
        reset = 1'b1;
        #1;
        check("mid_rst_an",   32'(an),           32'h1);
        check("mid_rst_seg",  32'(seg),          32'h3F);
        check("mid_rst_tens", 32'(bcd_tens),     32'h0);
        check("mid_rst_ones", 32'(bcd_ones),     32'h0);
        check("mid_rst_sel",  32'(dut.dig_sel),  32'h0);
        check("mid_rst_scan", 32'(dut.scan_cnt), 32'h0);
        reset = 1'b0;
        // Scan restarts on the ones digit: an stays 01 through edge 4.
        tick(4);
        check("mid_rel_an_e4", 32'(an), 32'h1);
        tick(1);
        check("mid_rel_an_e5", 32'(an), 32'h2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/count_seg_display.md
Name: count_seg_display

Overview:
- Downstream display stage for the 5-bit free-running event counter (reset value 5'h11, wraps 31→0).
- Samples the counter value, converts it to two BCD digits, and drives a 2-digit time-multiplexed 7-segment display.
- Flags counter wrap-around with a one-cycle pulse for the neighbouring control logic.

Parameters:
- SCAN_DIV, 4: clk cycles each digit stays selected; legal range ≥2.
- BLANK_LZ, 1: 1 = blank the tens digit when it is 0; 0 = always display it.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high
- count  in  5  counter value, unsigned 0..31
- hold  in  1  1 = freeze sampled value; display keeps scanning
- seg  out  7  segment drive, active-high, bit order {g,f,e,d,c,b,a}
- an  out  2  digit enable, one-hot, active-high; an[0] = ones, an[1] = tens
- bcd_tens  out  4  registered tens digit, 0..3
- bcd_ones  out  4  registered ones digit, 0..9
- wrap_pulse  out  1  one-cycle pulse on a sampled 31→0 transition

Behaviour:
- Reset is clk and reset, asynchronous, active-high. Reset values:
  - cap = 0, bcd_tens = 0, bcd_ones = 0, wrap_pulse = 0
  - scan_cnt = 0, dig_sel = 0, an = 2'b01, seg = 7'h3F
- Stage 1, capture:
  - Each clk edge with hold=0: cap <= count.
  - hold=1: cap retains its value.
- Wrap detect:
  - On an edge where hold=0, cap==31 and count==0: wrap_pulse <= 1.
  - Otherwise wrap_pulse <= 0.
  - Effect: wrap_pulse is high in the same cycle cap first reads 0.
  - hold=1 suppresses detection. Any other decrease, such as a counter reset to 17, does not pulse.
- Stage 2, BCD:
  - bcd_tens <= cap/10 and bcd_ones <= cap%10, registered.
  - Latency from count to BCD outputs: 2 cycles.
  - Implement with a compare/subtract chain (thresholds 10/20/30); no divider.
- Scan timer:
  - scan_cnt runs 0..SCAN_DIV-1 and wraps.
  - When scan_cnt==SCAN_DIV-1, dig_sel toggles.
  - Each digit is selected for exactly SCAN_DIV cycles; scan runs regardless of hold.
- Stage 3, output (registered):
  - an <= dig_sel ? 2'b10 : 2'b01.
  - seg <= encode(dig_sel ? bcd_tens : bcd_ones).
  - an and seg always change on the same edge, so no glitch between them.
- Segment encoding, 0..9: 3F, 06, 5B, 4F, 66, 6D, 7D, 07, 7F, 6F.
  - Any code >9 encodes to 7'h00; this cannot occur.
- Leading-zero blank:
  - With BLANK_LZ=1, dig_sel=1 and bcd_tens==0: seg <= 7'h00, while an still = 2'b10.
- Latency from count to seg: 3 cycles, provided the relevant digit is selected at that edge.
- Reset mid-operation:
  - All state returns to reset values immediately and asynchronously.
  - The scan restarts on the ones digit.
  - A pending wrap is discarded.
- Simultaneous events:
  - A hold rising edge in the same cycle as a 31→0 count: hold wins, so cap stays 31 and there is no pulse.

Test Plan:
- Reset asserted then released, count=0 → an=01, seg=3F, bcd_tens=0, bcd_ones=0, wrap_pulse=0. First dig_sel toggle occurs SCAN_DIV (4) cycles after release.
- Drive count=17 (counter reset value), hold=0 → bcd_tens=1, bcd_ones=7 two cycles later. seg=07 while an=01 and seg=06 while an=10, each held 4 cycles.
- Drive count 30, 31, 0, 1 on consecutive edges → wrap_pulse high exactly one cycle, coincident with cap=0. bcd_ones reads 0 the following cycle.
- Drive count 31 then 17, i.e. a counter reset → no wrap_pulse. BCD becomes 1/7.
- BLANK_LZ=1, count=5 → tens slot shows seg=00 with an=10; ones slot shows seg=6D. Repeat with BLANK_LZ=0 → tens slot shows seg=3F.
- hold=1 with count stepping 20→25 → BCD stays 2/0 and no wrap_pulse. Assert reset mid-scan at scan_cnt=2, dig_sel=1 → an=01, seg=3F immediately, before the next clk.
